// File: rtl/rr_arbiter16_pkg.sv
// Shared types and defaults for the 16-way round-robin arbiter.
package rr_arbiter16_pkg;

    localparam int unsigned NUM_REQ          = 16;
    localparam int unsigned IDX_W            = 4;
    localparam int unsigned MAX_HOLD_DEFAULT = 255;
    localparam int unsigned HOLD_W_DEFAULT   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_REL  = 2'd2
    } state_t;

endpackage

// File: rtl/decoder.sv
// 4-to-16 one-hot decoder with enable; i0 is the index MSB, d[k] is output k.
module decoder (
    input  logic        i0,
    input  logic        i1,
    input  logic        i2,
    input  logic        i3,
    input  logic        en,
    output logic [0:15] d
);

    always_comb begin
        d = '0;
        if (en) begin
            d[{i0, i1, i2, i3}] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter16_pick.sv
// Rotating-priority search: first set req bit at or after ptr, wrapping mod 16.
module rr_pick16
    import rr_arbiter16_pkg::*;
(
    input  logic [0:NUM_REQ-1] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] k;
    logic             found;

    always_comb begin
        idx   = '0;
        k     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = ptr + IDX_W'(i);
            if (!found && req[k]) begin
                idx   = k;
                found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters; grants are held until done,
// request drop, or hold timeout, with a two-cycle gap between grants.
module rr_arbiter16
    import rr_arbiter16_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int unsigned HOLD_W   = HOLD_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [0:NUM_REQ-1] req,
    input  logic               done,
    output logic [0:NUM_REQ-1] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               busy,
    output logic               timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] cnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              hold_expired;
    logic              owner_exit;

    rr_pick16 u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Owner-driven exits outrank the timeout so the pulse flags only pure expiry.
    assign owner_exit   = done || !req[gnt_idx];
    assign hold_expired = (MAX_HOLD != 0) && (cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt_idx <= pick_idx;
                        cnt     <= '0;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + HOLD_W'(1);
                    if (owner_exit) begin
                        state <= ST_REL;
                    end else if (hold_expired) begin
                        state   <= ST_REL;
                        timeout <= 1'b1;
                    end
                end
                ST_REL: begin
                    ptr   <= gnt_idx + IDX_W'(1);
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_BUSY);

    decoder u_dec (
        .i0 (gnt_idx[3]),
        .i1 (gnt_idx[2]),
        .i2 (gnt_idx[1]),
        .i3 (gnt_idx[0]),
        .en (state == ST_BUSY),
        .d  (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed self-checking bench for rr_arbiter16 built with a 4-cycle hold limit.
module tb_rr_arbiter16;

    logic        clk;
    logic        rst;
    logic [0:15] req;
    logic        done;
    logic [0:15] gnt;
    logic [3:0]  gnt_idx;
    logic        busy;
    logic        timeout;

    int checks;
    int failures;
    int cycle;
    int t_first;
    int t_second;

    rr_arbiter16 #(
        .MAX_HOLD (4),
        .HOLD_W   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:15] oh(input int k);
        logic [0:15] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cycle    = 0;
        t_first  = 0;
        t_second = 0;
        rst      = 1'b1;
        req      = '0;
        done     = 1'b0;

        // Reset state
        step();
        step();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset_idx", 32'(gnt_idx), 32'h0);
        chk("reset_timeout", 32'(timeout), 32'h0);

        // No requests for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step();
            chk_idle("noreq");
            chk("noreq_idx", 32'(gnt_idx), 32'h0);
        end

        // Single requester 5, done in its third grant cycle
        req[5] = 1'b1;
        step();
        chk("r5_gnt1", 32'(gnt), 32'(oh(5)));
        chk("r5_idx", 32'(gnt_idx), 32'd5);
        chk("r5_busy", 32'(busy), 32'h1);
        step();
        chk("r5_gnt2", 32'(gnt), 32'(oh(5)));
        step();
        chk("r5_gnt3", 32'(gnt), 32'(oh(5)));
        done = 1'b1;
        step();
        done = 1'b0;
        chk_idle("r5_rel");
        chk("r5_rel_timeout", 32'(timeout), 32'h0);
        req = '1;
        step();
        chk_idle("r5_gap");
        step();
        chk("after5_idx", 32'(gnt_idx), 32'd6);
        chk("after5_gnt", 32'(gnt), 32'(oh(6)));

        // Full round with everyone requesting and done every cycle
        rst = 1'b1;
        step();
        rst  = 1'b0;
        done = 1'b1;
        req  = '1;
        for (int r = 0; r < 17; r++) begin
            step();
            if (r == 0) t_first = cycle;
            if (r == 16) t_second = cycle;
            chk("round_idx", 32'(gnt_idx), 32'(r % 16));
            chk("round_gnt", 32'(gnt), 32'(oh(r % 16)));
            step();
            chk_idle("round_rel");
            step();
            chk_idle("round_gap");
        end
        chk("round_period", 32'(t_second - t_first), 32'd48);

        // Timeout on requester 9, then repeat with done in the 4th cycle
        rst = 1'b1;
        step();
        rst    = 1'b0;
        done   = 1'b0;
        req    = '0;
        req[9] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_gnt", 32'(gnt), 32'(oh(9)));
            chk("to_pulse_early", 32'(timeout), 32'h0);
        end
        step();
        chk_idle("to_rel");
        chk("to_pulse", 32'(timeout), 32'h1);
        step();
        chk("to_pulse_clear", 32'(timeout), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to2_gnt", 32'(gnt), 32'(oh(9)));
        end
        done = 1'b1;
        step();
        done = 1'b0;
        chk_idle("to2_rel");
        chk("to2_nopulse", 32'(timeout), 32'h0);

        // Request drop mid-grant
        rst = 1'b1;
        step();
        rst    = 1'b0;
        req    = '0;
        req[3] = 1'b1;
        step();
        chk("drop_gnt1", 32'(gnt), 32'(oh(3)));
        step();
        chk("drop_gnt2", 32'(gnt), 32'(oh(3)));
        req[3] = 1'b0;
        step();
        chk_idle("drop_rel");
        chk("drop_nopulse", 32'(timeout), 32'h0);

        // Reset while requester 12 is granted; pointer returns to 0
        req[12] = 1'b1;
        step();
        chk_idle("r12_gap");
        step();
        chk("r12_gnt", 32'(gnt), 32'(oh(12)));
        chk("r12_idx", 32'(gnt_idx), 32'd12);
        step();
        rst    = 1'b1;
        req[0] = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("midrst");
        chk("midrst_idx", 32'(gnt_idx), 32'h0);
        chk("midrst_timeout", 32'(timeout), 32'h0);
        step();
        chk("postrst_idx", 32'(gnt_idx), 32'd0);
        chk("postrst_gnt", 32'(gnt), 32'(oh(0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
